// File: rtl/alu_sequencer.sv
// Request/response sequencer wrapped around an external combinational ALU.
// Each accepted operation takes one EXEC cycle before its result and flags are held for the consumer.
module alu_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  input  logic [3:0]   req_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [N-1:0] alu_result,
  input  logic         alu_neg,
  input  logic         alu_zero,
  input  logic         alu_ovf,
  input  logic         alu_carry,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic [3:0]   sticky_flags,
  input  logic         clear_sticky,
  output logic [7:0]   op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] alu_a_q, alu_a_d;
  logic [N-1:0] alu_b_q, alu_b_d;
  logic [3:0]   alu_op_q, alu_op_d;
  logic [N-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]   rsp_flags_q, rsp_flags_d;
  logic [3:0]   sticky_q, sticky_d;
  logic [7:0]   op_count_q, op_count_d;
  logic         accept;
  logic         capture;
  logic [3:0]   alu_flags;

  // A response being taken frees the sequencer in the same cycle, allowing back-to-back accepts.
  assign req_ready = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_valid && req_ready;
  assign capture   = (state_q == EXEC);
  assign alu_flags = {alu_neg, alu_zero, alu_ovf, alu_carry};

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    sticky_d     = sticky_q;
    op_count_d   = op_count_q;

    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = req_valid ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      alu_a_d  = req_a;
      alu_b_d  = req_b;
      alu_op_d = req_op;
    end

    // A clear on the capture edge drops history but keeps the flags just captured.
    if (capture) begin
      rsp_result_d = alu_result;
      rsp_flags_d  = alu_flags;
      op_count_d   = op_count_q + 8'd1;
      sticky_d     = (clear_sticky ? 4'b0000 : sticky_q) | alu_flags;
    end else if (clear_sticky) begin
      sticky_d = 4'b0000;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      sticky_q     <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      sticky_q     <= sticky_d;
      op_count_q   <= op_count_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_flags    = rsp_flags_q;
  assign sticky_flags = sticky_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a stub ALU drives the alu_* inputs, a scoreboard queue holds the
// expected response for every accepted request, and a monitor pops and compares each response.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a, req_b;
  logic [3:0] req_op;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_neg, alu_zero, alu_ovf, alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;
  logic [3:0] sticky_flags;
  logic       clear_sticky;
  logic [7:0] op_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rsp_count = 0;
  int last_acc_cyc = 0;
  int last_rsp_cyc = 0;
  int prev_rsp_cyc = 0;

  typedef struct packed {
    logic [7:0] r;
    logic [3:0] f;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] r;
    logic [3:0] f;
  } vec_t;
  vec_t vecs[9];

  alu_sequencer #(.N(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result),
    .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .sticky_flags(sticky_flags), .clear_sticky(clear_sticky),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Stub ALU: 0 add, 1 sub (carry = borrow), 2 and, 3 or, 4 xor, otherwise pass a.
  function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic       v, c;
    s = 9'd0; v = 1'b0; c = 1'b0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0]; c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'd1: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[7:0]; c = s[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      default: r = a;
    endcase
    return {r[7], (r == 8'd0), v, c, r};
  endfunction

  logic [11:0] alu_out;
  assign alu_out    = alu_model(alu_a, alu_b, alu_op);
  assign alu_result = alu_out[7:0];
  assign {alu_neg, alu_zero, alu_ovf, alu_carry} = alu_out[11:8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: a handshake seen at the negedge completes on the following posedge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rsp_valid && rsp_ready) begin
      prev_rsp_cyc = last_rsp_cyc;
      last_rsp_cyc = cyc + 1;
      rsp_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got result %0h with no request outstanding", rsp_result);
      end else begin
        e = exp_q.pop_front();
        $display("rsp %0d: result=%h flags=%b expect result=%h flags=%b",
                 rsp_count, rsp_result, rsp_flags, e.r, e.f);
        chk("rsp_result", 32'(rsp_result), 32'(e.r));
        chk("rsp_flags", 32'(rsp_flags), 32'(e.f));
      end
    end
  end

  // Called just after a posedge; returns just after the edge that accepted the request.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       input logic [7:0] er, input logic [3:0] ef);
    bit ok;
    exp_t e;
    ok = 1'b0;
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      $display("FAIL accept_timeout: got req_ready=0 for 50 cycles expected 1");
      failures++; checks++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "accept timeout");
    end
    e.r = er; e.f = ef;
    exp_q.push_back(e);
    last_acc_cyc = cyc + 1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) return;
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0]  held_r;
    logic [3:0]  held_f;
    logic [7:0]  ra, rb;
    logic [3:0]  rop;
    logic [11:0] m;
    int          c0, n0;

    vecs[0] = '{8'hB5, 8'hAB, 4'd0, 8'h60, 4'b0011};
    vecs[1] = '{8'h05, 8'h07, 4'd1, 8'hFE, 4'b1001};
    vecs[2] = '{8'h0F, 8'hF0, 4'd2, 8'h00, 4'b0100};
    vecs[3] = '{8'h80, 8'h00, 4'd3, 8'h80, 4'b1000};
    vecs[4] = '{8'hAA, 8'h55, 4'd4, 8'hFF, 4'b1000};
    vecs[5] = '{8'h7F, 8'h01, 4'd0, 8'h80, 4'b1010};
    vecs[6] = '{8'hFF, 8'h02, 4'd0, 8'h01, 4'b0001};
    vecs[7] = '{8'h40, 8'h40, 4'd1, 8'h00, 4'b0100};
    vecs[8] = '{8'h33, 8'h99, 4'd5, 8'h33, 4'b0000};

    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
    rsp_ready = 1'b1; clear_sticky = 1'b0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_sticky", 32'(sticky_flags), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Single add with latency check
    do_op(8'hB5, 8'hAB, 4'd0, 8'h60, 4'b0011);
    chk("add_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("add_exec_req_ready", 32'(req_ready), 32'd0);
    chk("add_alu_regs", {12'd0, alu_a, alu_b, alu_op}, {12'd0, 8'hB5, 8'hAB, 4'd0});
    @(posedge clk); #1;
    chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("add_rsp_result", 32'(rsp_result), 32'h60);
    chk("add_op_count", 32'(op_count), 32'd1);
    chk("add_sticky", 32'(sticky_flags), 32'b0011);
    drain();

    // Table of operations
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].r, vecs[i].f);
      drain();
    end
    chk("table_op_count", 32'(op_count), 32'd10);
    chk("table_sticky", 32'(sticky_flags), 32'b1111);
    chk("table_rsp_count", 32'(rsp_count), 32'd10);

    // Backpressure
    rsp_ready = 1'b0;
    do_op(8'h12, 8'h34, 4'd0, 8'h46, 4'b0000);
    @(posedge clk); #1;
    held_r = rsp_result; held_f = rsp_flags;
    req_valid = 1'b1; req_a = 8'h09; req_b = 8'h03; req_op = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_result", 32'(rsp_result), 32'(held_r));
      chk("bp_rsp_flags", 32'(rsp_flags), 32'(held_f));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_alu_a_held", 32'(alu_a), 32'h12);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_req_ready", 32'(req_ready), 32'd1);
    do_op(8'h09, 8'h03, 4'd1, 8'h06, 4'b0000);
    chk("bp_pending_taken", 32'(alu_a), 32'h09);
    drain();

    // Back-to-back with req_valid held high
    n0 = int'(op_count);
    do_op(8'h01, 8'h01, 4'd0, 8'h02, 4'b0000);
    c0 = last_acc_cyc;
    do_op(8'h00, 8'h00, 4'd0, 8'h00, 4'b0100);
    chk("b2b_accept_gap", 32'(last_acc_cyc - c0), 32'd2);
    drain();
    chk("b2b_rsp_gap", 32'(last_rsp_cyc - prev_rsp_cyc), 32'd2);
    chk("b2b_op_count", 32'(op_count), 32'((n0 + 2) % 256));

    // Sticky accumulation and clear
    clear_sticky = 1'b1;
    @(posedge clk); #1;
    clear_sticky = 1'b0;
    chk("sticky_clear_idle", 32'(sticky_flags), 32'd0);
    do_op(8'h80, 8'h00, 4'd3, 8'h80, 4'b1000);
    drain();
    do_op(8'h0F, 8'hF0, 4'd2, 8'h00, 4'b0100);
    drain();
    chk("sticky_accum", 32'(sticky_flags), 32'b1100);
    do_op(8'hFF, 8'h02, 4'd0, 8'h01, 4'b0001);
    clear_sticky = 1'b1;
    @(posedge clk); #1;
    clear_sticky = 1'b0;
    chk("sticky_clear_on_capture", 32'(sticky_flags), 32'b0001);
    drain();

    // Asynchronous reset during EXEC
    n0 = rsp_count;
    do_op(8'h22, 8'h11, 4'd0, 8'h33, 4'b0000);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_alu_regs", {12'd0, alu_a, alu_b, alu_op}, 32'd0);
    chk("arst_rsp", {20'd0, rsp_result, rsp_flags}, 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_sticky", 32'(sticky_flags), 32'd0);
    chk("arst_op_count", 32'(op_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("arst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("arst_no_rsp_count", 32'(rsp_count), 32'(n0));
    chk("arst_op_count_after", 32'(op_count), 32'd0);

    // op_count wrap over 256 operations
    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 4'($urandom_range(0, 7));
      m = alu_model(ra, rb, rop);
      do_op(ra, rb, rop, m[7:0], m[11:8]);
      if (i == 254) begin
        drain();
        chk("wrap_op_count_255", 32'(op_count), 32'd255);
      end
    end
    drain();
    chk("wrap_op_count_0", 32'(op_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
